// File: rtl/writeback_unit_if.sv
// Execute-to-writeback handshake, load response and register-bank write port.
interface writeback_unit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instruction;
    logic [31:0] ex_alu_result;
    logic        ex_MemtoReg;
    logic        ex_RegWrite;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] MemtoRegMuxOutput;
    logic        load_timeout;

    modport master (
        output ex_valid, ex_instruction, ex_alu_result, ex_MemtoReg, ex_RegWrite,
        output mem_rvalid, mem_rdata,
        input  ex_ready, RegWrite, write_register, MemtoRegMuxOutput, load_timeout
    );

    modport slave (
        input  ex_valid, ex_instruction, ex_alu_result, ex_MemtoReg, ex_RegWrite,
        input  mem_rvalid, mem_rdata,
        output ex_ready, RegWrite, write_register, MemtoRegMuxOutput, load_timeout
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: retires one instruction per handshake, waits for load data
// with a bounded timeout, extracts/extends it and drives the register-bank write port.
module writeback_unit #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    writeback_unit_if.slave wb
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_regwrite;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [4:0]  r_wreg;
    logic [31:0] r_wdata;
    logic        r_tmo;

    logic        w_ready;
    logic        w_accept;
    logic        w_cnt_done;
    logic [4:0]  w_ex_rd;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_ex_rd    = wb.ex_instruction[11:7];
    assign w_accept   = wb.ex_valid && w_ready;
    assign w_cnt_done = (r_cnt == 8'(LOAD_TIMEOUT - 1));

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b1;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_accept) w_next = wb.ex_MemtoReg ? WAIT_MEM : COMMIT;
                else          w_next = IDLE;
            end
            WAIT_MEM: begin
                w_ready = 1'b0;
                // A response on the final count wins over the timeout.
                if (wb.mem_rvalid)     w_next = COMMIT;
                else if (w_cnt_done)   w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_shift = wb.mem_rdata >> {r_off, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = r_off[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
        case (r_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load = {24'd0, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = wb.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_regwrite <= 1'b0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            r_tmo   <= 1'b0;
            if (w_accept) begin
                r_rd       <= w_ex_rd;
                r_funct3   <= wb.ex_instruction[14:12];
                r_off      <= wb.ex_alu_result[1:0];
                r_regwrite <= wb.ex_RegWrite;
                r_cnt      <= '0;
                // Write port only moves when a write happens, so it holds otherwise.
                if (!wb.ex_MemtoReg && wb.ex_RegWrite && w_ex_rd != 5'd0) begin
                    r_we    <= 1'b1;
                    r_wreg  <= w_ex_rd;
                    r_wdata <= wb.ex_alu_result;
                end
            end
            if (r_state == WAIT_MEM) begin
                if (wb.mem_rvalid) begin
                    if (r_regwrite && r_rd != 5'd0) begin
                        r_we    <= 1'b1;
                        r_wreg  <= r_rd;
                        r_wdata <= w_load;
                    end
                end else if (w_cnt_done) begin
                    r_tmo <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign wb.ex_ready          = w_ready;
    assign wb.RegWrite          = r_we;
    assign wb.write_register    = r_wreg;
    assign wb.MemtoRegMuxOutput = r_wdata;
    assign wb.load_timeout      = r_tmo;
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage for the CPU: accepts one retiring instruction per handshake from the execute stage, waits a variable number of cycles for load data when needed, aligns and sign/zero-extends that data, and drives the write port of `register_bank`. It is the producer of `RegWrite`, `MemtoRegMuxOutput` and the destination register index consumed by the register bank. A load timeout guards against a hung memory.

## Interface
- `LOAD_TIMEOUT`, default 16: max cycles spent waiting for `mem_rvalid` before abort (range 1..255).
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `ex_valid`  input  1  execute stage presents an instruction.
- `ex_ready`  output  1  unit can accept this cycle (transfer when `ex_valid && ex_ready`).
- `ex_instruction`  input  32  retiring instruction; rd = [11:7], funct3 = [14:12].
- `ex_alu_result`  input  32  ALU result (address for loads).
- `ex_MemtoReg`  input  1  1 = write data comes from memory (load).
- `ex_RegWrite`  input  1  instruction writes a register.
- `mem_rvalid`  input  1  load response valid, single-cycle pulse.
- `mem_rdata`  input  32  aligned 32-bit word containing the load data.
- `RegWrite`  output  1  register-bank write enable.
- `write_register`  output  5  destination index.
- `MemtoRegMuxOutput`  output  32  write data.
- `load_timeout`  output  1  one-cycle pulse on load abort.

## Operation
- States: IDLE, WAIT_MEM, COMMIT.
- IDLE: `ex_ready`=1. On transfer, latch rd, funct3, alu_result[31:0], MemtoReg, RegWrite. MemtoReg=1 → WAIT_MEM (timeout counter cleared to 0); else → COMMIT with data = alu_result.
- WAIT_MEM: `ex_ready`=0. On `mem_rvalid`, latch extracted load data → COMMIT. Otherwise counter increments; when counter reaches LOAD_TIMEOUT-1 without response → pulse `load_timeout`, → IDLE, no write.
- COMMIT: `RegWrite` = latched RegWrite && rd != 0; `write_register` = rd; `MemtoRegMuxOutput` = latched data. `ex_ready`=1; a transfer in this cycle is handled exactly as in IDLE (back-to-back), else → IDLE.
- `mem_rvalid` outside WAIT_MEM is ignored. A response arriving in the same cycle as the final timeout count is accepted (response wins, no timeout pulse).
- Load extraction, off = alu_result[1:0]: funct3 0 LB = sign-extend byte off; 4 LBU = zero-extend byte off; 1 LH = sign-extend halfword off[1]; 5 LHU = zero-extend halfword off[1]; 2 LW and all other funct3 = full word, offset ignored. off[0] ignored for halfwords (no misalignment trap).
- Writes to x0 never assert `RegWrite`; the rest of the pipeline handshake is unaffected.

## Timing
- Reset: state IDLE, `RegWrite`=0, `write_register`=0, `MemtoRegMuxOutput`=0, `load_timeout`=0, counter 0. `ex_ready` is 1 in the cycle after reset deasserts. Reset mid-load discards the pending load; a later `mem_rvalid` is ignored.
- Outputs are registered. Non-load: accepted at edge N, `RegWrite` high in cycle N+1 only.
- Load: accepted at edge N, response sampled at edge M > N, `RegWrite` high in cycle M+1.
- Throughput: one non-load per cycle sustained; loads block new accepts until COMMIT.
- `RegWrite` is never high for two consecutive cycles for the same instruction; `write_register`/`MemtoRegMuxOutput` hold their last values when `RegWrite`=0.

## Test plan
- Reset, then 3 back-to-back ALU ops (rd=5,6,7; results 0x11,0x22,0x33) → `RegWrite` high 3 consecutive cycles with matching rd/data, `ex_ready` constantly 1.
- LB with alu_result=0x1003, funct3=0, rd=9, response after 4 cycles with mem_rdata=0x80FF_0000 → write x9 = 0xFFFF_FF80; `ex_ready`=0 during the wait; LBU same stimulus → 0x0000_0080.
- LH off=2 on 0x8001_1234 → 0xFFFF_8001; LHU → 0x0000_8001; LW → 0x8001_1234.
- ALU op to rd=0 with result 0xDEAD → `RegWrite` stays 0, next instruction accepted the following cycle.
- Load with no response, LOAD_TIMEOUT=16 → `load_timeout` pulses once 16 cycles after acceptance, no write, `ex_ready`=1 next cycle; late `mem_rvalid` ignored.
- Reset asserted during WAIT_MEM, then `mem_rvalid` → no write, all outputs at reset values, `ex_ready`=1 after reset drops.
